fetch_pc_ifid: RTL and testbench

- Fetch-stage PC generator plus IF/ID pipeline register for the 5-stage MIPS core.
- Selects the next PC from the branch predictor's predicted_PC, or from the ID-stage corrected PC when the predictor signals a misprediction (flushbp).
- Carries fetch PC, instruction and prediction metadata into ID so branch_predictionID-side logic can resolve and update the prediction.

---
 rtl/fetch_pc_ifid.sv | 119 +++++++++++
 tb/tb_fetch_pc_ifid.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ifid.sv
// Fetch-stage PC generator and IF/ID pipeline register for the 5-stage MIPS core.
// Optional saturating branch-predictor counters are enabled with `define BP_PERF_CNT_EN.
module fetch_pc_ifid #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic [31:0] predicted_PC,
  input  logic        pred_hit,
  input  logic        flushbp,
  input  logic [31:0] correct_PC,
  input  logic [31:0] instr_in,
`ifdef BP_PERF_CNT_EN
  output logic [31:0] bp_lookup_cnt,
  output logic [31:0] bp_hit_cnt,
  output logic [31:0] bp_flush_cnt,
`endif
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] predicted_PCD,
  output logic        pred_hitD,
  output logic        validD
);

  logic [31:0] r_pcf_p0;
  logic [31:0] r_instr_p1;
  logic [31:0] r_pc_p1;
  logic [31:0] r_pcplus4_p1;
  logic [31:0] r_pred_pc_p1;
  logic        r_pred_hit_p1;
  logic        vld_p1;

  logic [31:0] w_pcplus4;
  logic [31:0] w_next_pc;
  logic        w_capture;
  logic        w_bubble;

  // A misaligned prediction can never be a real target, so fall back to sequential fetch.
  assign w_pcplus4 = r_pcf_p0 + 32'd4;
  assign w_next_pc = (predicted_PC[1:0] != 2'b00) ? w_pcplus4 : predicted_PC;
  assign w_capture = !flushbp && !stallD && !stallF;
  assign w_bubble  = flushbp || (!stallD && stallF);

  // Stage p0: fetch PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf_p0 <= RESET_PC;
    end else if (flushbp) begin
      r_pcf_p0 <= correct_PC;
    end else if (!stallF) begin
      r_pcf_p0 <= w_next_pc;
    end
  end

  // Stage p1: IF/ID register; a stalled fetch feeds a bubble so the held instruction issues once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_p1    <= 32'd0;
      r_pc_p1       <= 32'd0;
      r_pcplus4_p1  <= 32'd0;
      r_pred_pc_p1  <= 32'd0;
      r_pred_hit_p1 <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (w_bubble) begin
      r_instr_p1    <= 32'd0;
      r_pc_p1       <= 32'd0;
      r_pcplus4_p1  <= 32'd0;
      r_pred_pc_p1  <= 32'd0;
      r_pred_hit_p1 <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (w_capture) begin
      r_instr_p1    <= instr_in;
      r_pc_p1       <= r_pcf_p0;
      r_pcplus4_p1  <= w_pcplus4;
      r_pred_pc_p1  <= w_next_pc;
      r_pred_hit_p1 <= pred_hit;
      vld_p1        <= 1'b1;
    end
  end

  assign PCF           = r_pcf_p0;
  assign InstrD        = r_instr_p1;
  assign PCD           = r_pc_p1;
  assign PCPlus4D      = r_pcplus4_p1;
  assign predicted_PCD = r_pred_pc_p1;
  assign pred_hitD     = r_pred_hit_p1;
  assign validD        = vld_p1;

`ifdef BP_PERF_CNT_EN
  logic [31:0] r_lookup_cnt;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_flush_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookup_cnt <= 32'd0;
      r_hit_cnt    <= 32'd0;
      r_flush_cnt  <= 32'd0;
    end else begin
      if (w_capture)             r_lookup_cnt <= sat_inc(r_lookup_cnt);
      if (w_capture && pred_hit) r_hit_cnt    <= sat_inc(r_hit_cnt);
      if (flushbp)               r_flush_cnt  <= sat_inc(r_flush_cnt);
    end
  end

  assign bp_lookup_cnt = r_lookup_cnt;
  assign bp_hit_cnt    = r_hit_cnt;
  assign bp_flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Directed bench for fetch_pc_ifid; counter checks are compiled only with `define BP_PERF_CNT_EN.
module tb_fetch_pc_ifid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, stallD, pred_hit, flushbp;
  logic [31:0] predicted_PC, correct_PC;
  logic [31:0] instr_in;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, predicted_PCD;
  logic        pred_hitD, validD;
`ifdef BP_PERF_CNT_EN
  logic [31:0] bp_lookup_cnt, bp_hit_cnt, bp_flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Combinational IMEM stand-in: instruction word is the bitwise inverse of its address.
  assign instr_in = ~PCF;

  fetch_pc_ifid #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD),
    .predicted_PC(predicted_PC), .pred_hit(pred_hit), .flushbp(flushbp),
    .correct_PC(correct_PC), .instr_in(instr_in),
`ifdef BP_PERF_CNT_EN
    .bp_lookup_cnt(bp_lookup_cnt), .bp_hit_cnt(bp_hit_cnt), .bp_flush_cnt(bp_flush_cnt),
`endif
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .predicted_PCD(predicted_PCD), .pred_hitD(pred_hitD), .validD(validD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pp, input logic ph, input logic fl,
                        input logic [31:0] cp, input logic sf, input logic sd);
    predicted_PC = pp; pred_hit = ph; flushbp = fl; correct_PC = cp; stallF = sf; stallD = sd;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_PCF", PCF, 32'h0040_0000);
    check("rst_InstrD", InstrD, 32'h0);
    check("rst_PCD", PCD, 32'h0);
    check("rst_PCPlus4D", PCPlus4D, 32'h0);
    check("rst_predPCD", predicted_PCD, 32'h0);
    check("rst_predhitD", {31'b0, pred_hitD}, 32'h0);
    check("rst_validD", {31'b0, validD}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    set_in(32'h0040_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rel_validD", {31'b0, validD}, 32'h0);
    check("rel_PCF", PCF, 32'h0040_0000);

    edge_step();
    check("seq1_PCF", PCF, 32'h0040_0004);
    check("seq1_validD", {31'b0, validD}, 32'h1);
    check("seq1_PCD", PCD, 32'h0040_0000);
    check("seq1_PCPlus4D", PCPlus4D, 32'h0040_0004);
    check("seq1_InstrD", InstrD, 32'hFFBF_FFFF);
    check("seq1_predPCD", predicted_PCD, 32'h0040_0004);

    set_in(32'h0040_0008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("seq2_PCF", PCF, 32'h0040_0008);
    check("seq2_PCD", PCD, 32'h0040_0004);
    set_in(32'h0040_000C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    set_in(32'h0040_0010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("seq4_PCF", PCF, 32'h0040_0010);

    // Predicted taken branch
    set_in(32'h0040_0100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("br_PCF", PCF, 32'h0040_0100);
    check("br_predhitD", {31'b0, pred_hitD}, 32'h1);
    check("br_predPCD", predicted_PCD, 32'h0040_0100);
    check("br_PCD", PCD, 32'h0040_0010);
    check("br_InstrD", InstrD, 32'hFFBF_FFEF);

    // Flush overrides both stalls
    set_in(32'h0040_0104, 1'b1, 1'b1, 32'h0040_0014, 1'b1, 1'b1);
    edge_step();
    check("fl_PCF", PCF, 32'h0040_0014);
    check("fl_validD", {31'b0, validD}, 32'h0);
    check("fl_InstrD", InstrD, 32'h0);
    check("fl_predhitD", {31'b0, pred_hitD}, 32'h0);

    set_in(32'h0040_0018, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("postfl_validD", {31'b0, validD}, 32'h1);
    check("postfl_PCD", PCD, 32'h0040_0014);
    set_in(32'h0040_001C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    set_in(32'h0040_0020, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("pre_stall_PCF", PCF, 32'h0040_0020);

    // stallF without stallD: PC holds, ID sees bubbles
    set_in(32'h0040_0024, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    edge_step();
    check("stf1_PCF", PCF, 32'h0040_0020);
    check("stf1_validD", {31'b0, validD}, 32'h0);
    edge_step();
    check("stf2_PCF", PCF, 32'h0040_0020);
    check("stf2_validD", {31'b0, validD}, 32'h0);
    set_in(32'h0040_0024, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("stfrel_PCF", PCF, 32'h0040_0024);
    check("stfrel_validD", {31'b0, validD}, 32'h1);
    check("stfrel_PCD", PCD, 32'h0040_0020);
    check("stfrel_InstrD", InstrD, 32'hFFBF_FFDF);
    set_in(32'h0040_0028, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("once_PCD", PCD, 32'h0040_0024);

    // Both stalls: everything holds
    set_in(32'h0040_002C, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    edge_step();
    check("hold_PCF", PCF, 32'h0040_0028);
    check("hold_PCD", PCD, 32'h0040_0024);
    check("hold_validD", {31'b0, validD}, 32'h1);
    check("hold_predhitD", {31'b0, pred_hitD}, 32'h0);

    // Wrap-around with misaligned prediction
    set_in(32'h0040_002C, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    edge_step();
    check("wrapfl_PCF", PCF, 32'hFFFF_FFFC);
    set_in(32'h0000_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("wrap_PCF", PCF, 32'h0000_0000);
    check("wrap_PCD", PCD, 32'hFFFF_FFFC);
    check("wrap_PCPlus4D", PCPlus4D, 32'h0000_0000);
    check("wrap_predPCD", predicted_PCD, 32'h0000_0000);
    check("wrap_validD", {31'b0, validD}, 32'h1);

    // Asynchronous reset in the middle of a stalled cycle
    set_in(32'h0000_0008, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_PCF", PCF, 32'h0040_0000);
    check("arst_validD", {31'b0, validD}, 32'h0);
    check("arst_PCD", PCD, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(32'h0040_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef BP_PERF_CNT_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check("cnt_rst_lookup", bp_lookup_cnt, 32'h0);
    for (int i = 0; i < 2; i++) begin
      set_in(PCF + 32'd4, 1'b0, 1'b1, 32'h0040_0000, 1'b0, 1'b0);
      edge_step();
    end
    for (int i = 0; i < 10; i++) begin
      set_in(PCF + 32'd4, (i < 4), 1'b0, 32'h0, 1'b0, 1'b0);
      edge_step();
    end
    check("cnt_lookup", bp_lookup_cnt, 32'd10);
    check("cnt_hit", bp_hit_cnt, 32'd4);
    check("cnt_flush", bp_flush_cnt, 32'd2);
    @(negedge clk);
    force dut.r_lookup_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_lookup_cnt;
    set_in(PCF + 32'd4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    edge_step();
    check("cnt_sat", bp_lookup_cnt, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
